vcmux_rr_credit: RTL and testbench

//  Parametrised N-VC output multiplexer for one router output port: picks one input VC per cycle,

---
 rtl/vcmux_rr_credit.sv | 175 +++++++++++++++++
 tb/tb_vcmux_rr_credit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vcmux_rr_credit.sv
// vcmux_rr_credit: N-VC output multiplexer for one router output port.
// Round-robin arbitration with packet hold, per-VC downstream credit
// tracking, and a single registered output stage towards the link.
module vcmux_rr_credit #(
    parameter  int NVC     = 4,
    parameter  int DATAW   = 64,
    parameter  int PORTW   = 5,
    parameter  int DSTW    = 5,
    parameter  int CREDITS = 4,
    localparam int VCW     = $clog2(NVC)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [NVC-1:0]       ivalid,
    input  logic [NVC*DATAW-1:0] idata,
    input  logic [NVC-1:0]       ireq,
    input  logic [NVC*PORTW-1:0] iport,
    input  logic [NVC*DSTW-1:0]  imultab,
    input  logic [NVC-1:0]       credit_in,
    output logic                 ovalid,
    output logic [DATAW-1:0]     odata,
    output logic [VCW-1:0]       ovch,
    output logic [NVC-1:0]       vcsel,
    output logic                 req,
    output logic [PORTW-1:0]     port,
    output logic [DSTW-1:0]      multab_en,
    output logic [NVC-1:0]       sent,
    output logic [NVC-1:0]       crd_zero,
    output logic                 crd_err
);

    // Credit counters hold 0..15, enough for any legal CREDITS value.
    localparam int CW = 4;

    logic [NVC-1:0]   last_r;
    logic [VCW-1:0]   rr_ptr_r;
    logic [CW-1:0]    credit_r     [NVC];
    logic [CW-1:0]    credit_nxt_s [NVC];
    logic [NVC-1:0]   nz_s;
    logic [NVC-1:0]   elig_s;
    logic [NVC-1:0]   hold_s;
    logic [NVC-1:0]   vcsel_s;
    logic [NVC-1:0]   sent_s;
    logic [NVC-1:0]   err_s;
    logic [VCW-1:0]   grant_idx_s;
    logic [DATAW-1:0] data_sel_s;

    // Binary index of a one-hot (or zero) vector; zero maps to index 0.
    function automatic logic [VCW-1:0] onehot_idx(input logic [NVC-1:0] v);
        logic [VCW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NVC; i++) begin
            idx = v[i] ? VCW'(i) : idx;
        end
        return idx;
    endfunction

    // A VC may win arbitration only if it requests and has downstream space.
    always_comb begin
        nz_s   = '0;
        elig_s = '0;
        for (int i = 0; i < NVC; i++) begin
            nz_s[i]   = (credit_r[i] != CW'(0));
            elig_s[i] = ireq[i] & nz_s[i];
        end
    end

    // Grant: the current packet owner keeps the output (even when stalled on
    // credit); otherwise the first eligible VC after rr_ptr wins.
    always_comb begin
        logic [NVC-1:0] pick_hi_s;
        logic [NVC-1:0] pick_lo_s;
        logic           found_hi_s;
        logic           found_lo_s;
        pick_hi_s  = '0;
        pick_lo_s  = '0;
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        hold_s     = last_r & ireq;
        for (int i = 0; i < NVC; i++) begin
            if (elig_s[i] && !found_hi_s && (i > int'(rr_ptr_r))) begin
                pick_hi_s[i] = 1'b1;
                found_hi_s   = 1'b1;
            end else if (elig_s[i] && !found_lo_s && (i <= int'(rr_ptr_r))) begin
                pick_lo_s[i] = 1'b1;
                found_lo_s   = 1'b1;
            end else begin
                pick_hi_s[i] = pick_hi_s[i];
            end
        end
        if (|hold_s) begin
            vcsel_s = hold_s;
        end else if (found_hi_s) begin
            vcsel_s = pick_hi_s;
        end else begin
            vcsel_s = pick_lo_s;
        end
    end

    // Launch, index encode and per-VC field muxing for the granted VC.
    always_comb begin
        sent_s      = vcsel_s & ivalid & nz_s;
        grant_idx_s = onehot_idx(vcsel_s);
        data_sel_s  = '0;
        port        = '0;
        multab_en   = '0;
        for (int i = 0; i < NVC; i++) begin
            data_sel_s = data_sel_s | (vcsel_s[i] ? idata[i*DATAW +: DATAW] : '0);
            port       = port       | (vcsel_s[i] ? iport[i*PORTW +: PORTW] : '0);
            multab_en  = multab_en  | (vcsel_s[i] ? imultab[i*DSTW +: DSTW] : '0);
        end
    end

    // Next credit value per VC; a return while already full is an error and is dropped.
    always_comb begin
        err_s = '0;
        for (int i = 0; i < NVC; i++) begin
            credit_nxt_s[i] = credit_r[i];
            case ({sent_s[i], credit_in[i]})
                2'b10: credit_nxt_s[i] = credit_r[i] - CW'(1);
                2'b01: begin
                    if (credit_r[i] == CW'(CREDITS)) begin
                        err_s[i] = 1'b1;
                    end else begin
                        credit_nxt_s[i] = credit_r[i] + CW'(1);
                    end
                end
                default: credit_nxt_s[i] = credit_r[i];
            endcase
        end
    end

    // Arbitration history, credit counters and credit status flags.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            last_r   <= '0;
            rr_ptr_r <= VCW'(NVC - 1);
            crd_zero <= '0;
            crd_err  <= 1'b0;
            for (int i = 0; i < NVC; i++) begin
                credit_r[i] <= CW'(CREDITS);
            end
        end else begin
            last_r <= vcsel_s;
            if ((|vcsel_s) && (vcsel_s != last_r)) begin
                rr_ptr_r <= grant_idx_s;
            end
            crd_err <= crd_err | (|err_s);
            for (int i = 0; i < NVC; i++) begin
                credit_r[i] <= credit_nxt_s[i];
                crd_zero[i] <= (credit_nxt_s[i] == CW'(0));
            end
        end
    end

    // Registered output stage; data and VC index hold their last launched value.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            ovalid <= 1'b0;
            odata  <= '0;
            ovch   <= '0;
        end else begin
            ovalid <= |sent_s;
            if (|sent_s) begin
                odata <= data_sel_s;
                ovch  <= grant_idx_s;
            end
        end
    end

    assign vcsel = vcsel_s;
    assign sent  = sent_s;
    assign req   = |ireq;

endmodule

// File: tb/tb_vcmux_rr_credit.sv
// Directed self-checking bench for vcmux_rr_credit (NVC=4, CREDITS=4).
module tb_vcmux_rr_credit;

    localparam int NVC   = 4;
    localparam int DATAW = 64;
    localparam int PORTW = 5;
    localparam int DSTW  = 5;
    localparam int VCW   = 2;

    logic                 clk = 1'b0;
    logic                 rst_;
    logic [NVC-1:0]       ivalid;
    logic [NVC*DATAW-1:0] idata;
    logic [NVC-1:0]       ireq;
    logic [NVC*PORTW-1:0] iport;
    logic [NVC*DSTW-1:0]  imultab;
    logic [NVC-1:0]       credit_in;
    logic                 ovalid;
    logic [DATAW-1:0]     odata;
    logic [VCW-1:0]       ovch;
    logic [NVC-1:0]       vcsel;
    logic                 req;
    logic [PORTW-1:0]     port;
    logic [DSTW-1:0]      multab_en;
    logic [NVC-1:0]       sent;
    logic [NVC-1:0]       crd_zero;
    logic                 crd_err;

    int n_cmp = 0;
    int n_err = 0;

    vcmux_rr_credit #(.NVC(NVC), .DATAW(DATAW), .PORTW(PORTW), .DSTW(DSTW), .CREDITS(4)) dut (
        .clk(clk), .rst_(rst_), .ivalid(ivalid), .idata(idata), .ireq(ireq),
        .iport(iport), .imultab(imultab), .credit_in(credit_in),
        .ovalid(ovalid), .odata(odata), .ovch(ovch), .vcsel(vcsel), .req(req),
        .port(port), .multab_en(multab_en), .sent(sent), .crd_zero(crd_zero),
        .crd_err(crd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] flit(input int vc, input int s);
        return {48'h0, 8'(vc), 8'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int s);
        for (int i = 0; i < NVC; i++) begin
            idata[i*DATAW +: DATAW] = flit(i, s);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic [3:0] c);
        ireq      = r;
        ivalid    = v;
        credit_in = c;
        #1;
    endtask

    initial begin
        logic [3:0] exp_v;
        rst_ = 1'b0;
        for (int i = 0; i < NVC; i++) begin
            iport[i*PORTW +: PORTW]  = 5'(i + 1);
            imultab[i*DSTW +: DSTW]  = 5'(16 + i);
        end
        set_data(0);
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_odata", odata, 64'd0);
        chk("rst_ovch", 64'(ovch), 64'd0);
        chk("rst_crd_zero", 64'(crd_zero), 64'd0);
        chk("rst_crd_err", 64'(crd_err), 64'd0);
        chk("rst_vcsel", 64'(vcsel), 64'd0);
        chk("rst_req", 64'(req), 64'd0);
        rst_ = 1'b1;

        // 1: fairness with single-flit packets
        for (int k = 0; k < 5; k++) begin
            set_data(k);
            if (k == 0) drive(4'b1111, 4'b1111, 4'b0000);
            else        drive(~(4'b0001 << ((k - 1) % 4)), 4'b1111, 4'b0000);
            exp_v = 4'b0001 << (k % 4);
            chk("t1_vcsel", 64'(vcsel), 64'(exp_v));
            chk("t1_sent", 64'(sent), 64'(exp_v));
            chk("t1_port", 64'(port), 64'((k % 4) + 1));
            chk("t1_multab", 64'(multab_en), 64'(16 + (k % 4)));
            chk("t1_req", 64'(req), 64'd1);
            tick();
            chk("t1_ovalid", 64'(ovalid), 64'd1);
            chk("t1_ovch", 64'(ovch), 64'(k % 4));
            chk("t1_odata", odata, flit(k % 4, k));
        end
        // restore credits (VC0 at 2, others at 3)
        drive(4'b0000, 4'b0000, 4'b1111);
        chk("idle_vcsel", 64'(vcsel), 64'd0);
        tick();
        chk("idle_ovalid", 64'(ovalid), 64'd0);
        chk("idle_odata_hold", odata, flit(0, 4));
        drive(4'b0000, 4'b0000, 4'b0001);
        tick();
        chk("restore1_err", 64'(crd_err), 64'd0);

        // 2: VC1 packet holds 5 cycles against VC2; credits returned in step
        for (int k = 0; k < 5; k++) begin
            set_data(16 + k);
            drive(4'b0110, 4'b0110, 4'b0010);
            chk("t2_vcsel_hold", 64'(vcsel), 64'(4'b0010));
            chk("t2_sent", 64'(sent), 64'(4'b0010));
            tick();
            chk("t2_odata", odata, flit(1, 16 + k));
        end
        set_data(32);
        drive(4'b0100, 4'b0100, 4'b0000);
        chk("t2_vcsel_next", 64'(vcsel), 64'(4'b0100));
        tick();
        chk("t2_odata_vc2", odata, flit(2, 32));
        chk("t2_ovch_vc2", 64'(ovch), 64'd2);
        drive(4'b0000, 4'b0000, 4'b0100);
        tick();

        // 3: VC0 streams until credits run out, then one credit allows one flit
        for (int k = 0; k < 4; k++) begin
            set_data(48 + k);
            drive(4'b0001, 4'b0001, 4'b0000);
            chk("t3_sent", 64'(sent), 64'(4'b0001));
            tick();
            chk("t3_crd_zero", 64'(crd_zero), (k == 3) ? 64'(4'b0001) : 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(4'b0001, 4'b0001, 4'b0000);
            chk("t3_stall_vcsel", 64'(vcsel), 64'(4'b0001));
            chk("t3_stall_sent", 64'(sent), 64'd0);
            tick();
            chk("t3_stall_ovalid", 64'(ovalid), 64'd0);
        end
        drive(4'b0001, 4'b0001, 4'b0001);
        chk("t3_cin_sent", 64'(sent), 64'd0);
        tick();
        chk("t3_cin_zero", 64'(crd_zero), 64'd0);
        set_data(60);
        drive(4'b0001, 4'b0001, 4'b0000);
        chk("t3_one_more", 64'(sent), 64'(4'b0001));
        tick();
        chk("t3_one_ovalid", 64'(ovalid), 64'd1);
        chk("t3_one_odata", odata, flit(0, 60));
        drive(4'b0001, 4'b0001, 4'b0000);
        chk("t3_no_more", 64'(sent), 64'd0);
        tick();

        // 4: drain VC3, park rr_ptr on VC2, then VC3 (no credit) is skipped for VC1
        for (int k = 0; k < 4; k++) begin
            drive(4'b1000, 4'b1000, 4'b0000);
            chk("t4_vc3_sent", 64'(sent), 64'(4'b1000));
            tick();
        end
        chk("t4_crd_zero", 64'(crd_zero), 64'(4'b1001));
        drive(4'b0100, 4'b0000, 4'b0000);
        chk("t4_vc2_grant", 64'(vcsel), 64'(4'b0100));
        tick();
        drive(4'b1010, 4'b1010, 4'b0000);
        chk("t4_skip_vc3", 64'(vcsel), 64'(4'b0010));
        chk("t4_port", 64'(port), 64'd2);
        tick();
        chk("t4_ovch", 64'(ovch), 64'd1);

        // 5: simultaneous send and return keep VC2 at 4 credits
        for (int k = 0; k < 10; k++) begin
            drive(4'b0100, 4'b0100, 4'b0100);
            chk("t5_sent_both", 64'(sent), 64'(4'b0100));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, 4'b0100, 4'b0000);
            chk("t5_drain", 64'(sent), (k < 4) ? 64'(4'b0100) : 64'd0);
            tick();
        end
        chk("t5_err_clean", 64'(crd_err), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, 4'b0000, 4'b1101);
            tick();
        end
        drive(4'b0000, 4'b0000, 4'b0010);
        tick();
        chk("t5_full_zero", 64'(crd_zero), 64'd0);
        chk("t5_full_err0", 64'(crd_err), 64'd0);
        drive(4'b0000, 4'b0000, 4'b0001);
        tick();
        chk("t5_err_set", 64'(crd_err), 64'd1);
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        chk("t5_err_sticky", 64'(crd_err), 64'd1);

        // 6: reset in the middle of a VC2 packet holding one credit
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 4'b0100, 4'b0000);
            tick();
        end
        drive(4'b0100, 4'b0000, 4'b0000);
        chk("t6_hold", 64'(vcsel), 64'(4'b0100));
        tick();
        rst_ = 1'b0;
        drive(4'b0100, 4'b0100, 4'b0000);
        chk("t6_last_credit", 64'(sent), 64'(4'b0100));
        tick();
        chk("t6_ovalid", 64'(ovalid), 64'd0);
        chk("t6_odata", odata, 64'd0);
        chk("t6_crd_err", 64'(crd_err), 64'd0);
        chk("t6_crd_zero", 64'(crd_zero), 64'd0);
        rst_ = 1'b1;
        drive(4'b0101, 4'b0000, 4'b0000);
        chk("t6_restart_vc0", 64'(vcsel), 64'(4'b0001));
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, 4'b0100, 4'b0000);
            chk("t6_vc2_credits", 64'(sent), (k < 4) ? 64'(4'b0100) : 64'd0);
            tick();
        end
        chk("t6_vc2_zero", 64'(crd_zero), 64'(4'b0100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
